// File: rtl/job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : job_dispatcher
// Brief    : Request FIFO feeding a start/done sequencer. Issues one job at a
//            time, reports each completion with its ID, and recovers through a
//            watchdog when the sequencer never signals done.
// Revision : 1.0 - initial release
// ============================================================================
module job_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [ID_W-1:0]          req_id,
    output logic                     req_ready,
    output logic                     start,
    input  logic                     done,
    output logic                     cmpl_valid,
    output logic [ID_W-1:0]          cmpl_id,
    output logic                     cmpl_timeout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [AW:0]   c_DEPTH      = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ID_W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;

    logic [ID_W-1:0]    r_cur_id;
    logic [TW-1:0]      r_timer;
    logic               r_start;
    logic               r_cmpl_valid;
    logic [ID_W-1:0]    r_cmpl_id;
    logic               r_cmpl_timeout;
    logic               r_drop_err;

    logic               w_req_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_finish;
    logic               w_timed_out;

    // Full blocks new requests even when a pop happens on the same edge.
    assign w_req_ready  = (r_count < c_DEPTH);
    assign w_push       = req_valid && w_req_ready;

    assign req_ready    = w_req_ready;
    assign start        = r_start;
    assign cmpl_valid   = r_cmpl_valid;
    assign cmpl_id      = r_cmpl_id;
    assign cmpl_timeout = r_cmpl_timeout;
    assign busy         = (r_state == WAIT) || (r_count != '0);
    assign queue_count  = r_count;
    assign drop_err     = r_drop_err;

    // Next-state decode: pop when idle with work queued; finish on done or watchdog (done wins).
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_finish     = 1'b0;
        w_timed_out  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (done) begin
                    w_finish     = 1'b1;
                    w_state_next = IDLE;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_finish     = 1'b1;
                    w_timed_out  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Circular request buffer; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= req_id;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Job tracking: start pulse, watchdog timer and completion report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_id       <= '0;
            r_timer        <= '0;
            r_start        <= 1'b0;
            r_cmpl_valid   <= 1'b0;
            r_cmpl_id      <= '0;
            r_cmpl_timeout <= 1'b0;
        end else begin
            r_start      <= w_pop;
            r_cmpl_valid <= w_finish;
            if (w_pop) begin
                r_cur_id <= r_mem[r_rd_ptr];
                r_timer  <= '0;
            end else if ((r_state == WAIT) && !w_finish) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_finish) begin
                r_cmpl_id      <= r_cur_id;
                r_cmpl_timeout <= w_timed_out;
            end
        end
    end

    // Sticky overflow flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_err <= 1'b0;
        end else if (req_valid && !w_req_ready) begin
            r_drop_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_job_dispatcher
// Brief    : Directed bench for job_dispatcher with a completion scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_job_dispatcher;

    localparam int DEPTH   = 4;
    localparam int ID_W    = 4;
    localparam int TIMEOUT = 64;

    logic                   clk;
    logic                   reset;
    logic                   req_valid;
    logic [ID_W-1:0]        req_id;
    logic                   req_ready;
    logic                   start;
    logic                   done;
    logic                   cmpl_valid;
    logic [ID_W-1:0]        cmpl_id;
    logic                   cmpl_timeout;
    logic                   busy;
    logic [$clog2(DEPTH):0] queue_count;
    logic                   drop_err;

    int n_pass  = 0;
    int n_total = 0;

    // Expected completions: {timeout, id}
    logic [ID_W:0] exp_q[$];

    job_dispatcher #(
        .DEPTH   (DEPTH),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_id       (req_id),
        .req_ready    (req_ready),
        .start        (start),
        .done         (done),
        .cmpl_valid   (cmpl_valid),
        .cmpl_id      (cmpl_id),
        .cmpl_timeout (cmpl_timeout),
        .busy         (busy),
        .queue_count  (queue_count),
        .drop_err     (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cmpl(input logic [ID_W-1:0] id, input logic to);
        exp_q.push_back({to, id});
    endtask

    task automatic wait_start(input string name);
        int k;
        k = 0;
        while (!start && k < 100) begin
            tick();
            k++;
        end
        check(name, start, 1);
    endtask

    // Scoreboard monitor: every completion report must match the oldest expectation.
    always @(negedge clk) begin
        if (cmpl_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected cmpl_valid", 1, 0);
            end else begin
                logic [ID_W:0] e;
                e = exp_q.pop_front();
                check("cmpl_id", cmpl_id, e[ID_W-1:0]);
                check("cmpl_timeout", cmpl_timeout, e[ID_W]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [ID_W-1:0] id;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_id    = '0;
        done      = 1'b0;
        tick(); tick();
        check("reset start", start, 0);
        check("reset cmpl_valid", cmpl_valid, 0);
        check("reset cmpl_id", cmpl_id, 0);
        check("reset busy", busy, 0);
        check("reset queue_count", queue_count, 0);
        check("reset req_ready", req_ready, 1);
        check("reset drop_err", drop_err, 0);
        reset = 1'b0;
        tick();

        // Single job: push 3, done 4 cycles after start
        expect_cmpl(4'd3, 1'b0);
        req_valid = 1'b1; req_id = 4'd3;
        tick();                                   // edge N
        req_valid = 1'b0;
        check("single start before pop", start, 0);
        check("single count after push", queue_count, 1);
        tick();                                   // edge N+1 = S
        check("single start", start, 1);
        check("single busy", busy, 1);
        tick();                                   // S+1
        check("single start drops", start, 0);
        tick(); tick();                           // S+2, S+3
        done = 1'b1;
        tick();                                   // S+4
        done = 1'b0;
        check("single cmpl pulse", cmpl_valid, 1);
        tick();
        check("single cmpl one cycle", cmpl_valid, 0);
        check("single busy clear", busy, 0);

        // Fill and order
        for (int i = 1; i <= 5; i++) begin
            expect_cmpl(ID_W'(i), 1'b0);
            req_valid = 1'b1; req_id = ID_W'(i);
            tick();
        end
        check("fill req_ready", req_ready, 0);
        check("fill queue_count", queue_count, 4);
        check("fill drop_err before", drop_err, 0);
        req_id = 4'd6;
        tick();                                   // dropped
        req_valid = 1'b0;
        check("fill drop_err", drop_err, 1);
        check("fill count after drop", queue_count, 4);
        for (int j = 0; j < 5; j++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            check("fill cmpl pulse", cmpl_valid, 1);
            check("fill no start with cmpl", start, 0);
            tick();
            if (j < 4) check("fill gap start", start, 1);
        end
        check("fill drained", busy, 0);

        // Watchdog on job 7, then coincident done/timeout on job 8
        expect_cmpl(4'd7, 1'b1);
        expect_cmpl(4'd8, 1'b0);
        req_valid = 1'b1; req_id = 4'd7;
        tick();
        req_id = 4'd8;
        tick();                                   // S
        req_valid = 1'b0;
        check("wd start", start, 1);
        for (int k = 0; k < TIMEOUT - 1; k++) tick();
        check("wd not yet", cmpl_valid, 0);
        tick();                                   // S+64
        check("wd cmpl_valid", cmpl_valid, 1);
        check("wd cmpl_timeout", cmpl_timeout, 1);
        tick();                                   // S'
        check("wd next start", start, 1);
        for (int k = 0; k < TIMEOUT - 1; k++) tick();
        done = 1'b1;
        tick();                                   // S'+64
        done = 1'b0;
        check("coincide cmpl_valid", cmpl_valid, 1);
        check("coincide timeout", cmpl_timeout, 0);
        tick();

        // Stray done while idle and empty
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("stray busy", busy, 0);
        check("stray start", start, 0);
        check("stray count", queue_count, 0);

        // Nine push/complete rounds through the wrapping FIFO
        for (int i = 0; i < 9; i++) begin
            id = ID_W'((i * 5 + 2) % 16);
            expect_cmpl(id, 1'b0);
            req_valid = 1'b1; req_id = id;
            tick();
            req_valid = 1'b0;
            wait_start("wrap start");
            done = 1'b1;
            tick();
            done = 1'b0;
            tick();
        end

        // Reset mid-job with two queued
        req_valid = 1'b1; req_id = 4'd10;
        tick();
        req_id = 4'd11;
        tick();
        req_id = 4'd12;
        tick();
        req_valid = 1'b0;
        check("rst pre count", queue_count, 2);
        check("rst pre busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst async start", start, 0);
        check("rst async busy", busy, 0);
        check("rst async count", queue_count, 0);
        check("rst async ready", req_ready, 1);
        check("rst async drop_err", drop_err, 0);
        check("rst async cmpl_id", cmpl_id, 0);
        req_valid = 1'b1; req_id = 4'd13;
        tick(); tick();
        reset = 1'b0;
        req_valid = 1'b0;
        tick(); tick(); tick();
        check("post rst count", queue_count, 0);
        check("post rst busy", busy, 0);
        check("post rst start", start, 0);
        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/job_dispatcher.md
# job_dispatcher

Queues job requests and feeds them one at a time to the A→B→C sequencer FSM. The block sits directly upstream of that sequencer: it drives the sequencer's `start` pulse and consumes its `done` pulse. Each job ends with a completion report carrying the job ID, and a watchdog timeout forces recovery when `done` never arrives.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO depth; power of two, ≥2.
- `ID_W`, 4: job ID width.
- `TIMEOUT`, 64: watchdog limit in cycles; ≥2.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `req_valid` input 1: job request present.
- `req_id` input ID_W: ID of the requested job.
- `req_ready` output 1: FIFO can accept a request; combinational, equals `count < DEPTH`.
- `start` output 1: one-cycle pulse to the sequencer.
- `done` input 1: completion pulse from the sequencer.
- `cmpl_valid` output 1: one-cycle completion report.
- `cmpl_id` output ID_W: ID of the reported job.
- `cmpl_timeout` output 1: when 1, the reported job ended by watchdog rather than by `done`.
- `busy` output 1: `(state==WAIT) || (count!=0)`.
- `queue_count` output clog2(DEPTH)+1: current FIFO occupancy.
- `drop_err` output 1: sticky; set when a request is presented while full.

## Operation
- FIFO
  - Circular buffer of `DEPTH` entries with read/write pointers and an occupancy count.
  - Push on a posedge when `req_valid && req_ready`.
- FSM state `IDLE`
  - If `count != 0` at a posedge: pop the head into `cur_id`, register `start<=1`, clear `timer<=0`, go to `WAIT`.
  - If `count == 0`: stay in `IDLE`.
- FSM state `WAIT`
  - `start<=0`; `timer<=timer+1`.
  - If `done`=1: register `cmpl_valid<=1`, `cmpl_id<=cur_id`, `cmpl_timeout<=0`, go to `IDLE`.
  - Else if `timer==TIMEOUT-1`: register `cmpl_valid<=1`, `cmpl_id<=cur_id`, `cmpl_timeout<=1`, go to `IDLE`.
- `cmpl_valid` defaults to 0 on every edge where it is not set; `cmpl_id` and `cmpl_timeout` hold their values until the next report.
- `done` arriving in `IDLE` is ignored and has no side effect.
- `drop_err` is set when `req_valid && !req_ready` at a posedge. It clears only on reset.
- Timer width is clog2(TIMEOUT) bits and never wraps, because the FSM leaves `WAIT` when the timer reaches `TIMEOUT-1`.

## Timing
- Reset values: `start`=0, `cmpl_valid`=0, `cmpl_id`=0, `cmpl_timeout`=0, `drop_err`=0, `busy`=0, `queue_count`=0, `req_ready`=1, state `IDLE`, pointers 0, `timer` 0.
  - Requests presented while `reset` is high are not stored.
- Request latency: a request accepted into an empty, idle block at edge N is popped at edge N+1. `start` is high from N+1 to N+2.
- `done` is sampled on every `WAIT` edge, including the first edge after `start` rises.
- Watchdog: after `start` rises at edge S, `done` is checked at edges S+1 … S+TIMEOUT.
  - With no `done`, the timeout report is registered at edge S+TIMEOUT.
  - If `done` and the timeout coincide at the same edge, `done` wins: `cmpl_timeout`=0.
- Back-to-back jobs: a completion at edge M returns the FSM to `IDLE`. The next pop and `start` occur at edge M+1, so there is exactly one gap cycle.
  - `cmpl_valid` for the previous job and `start` for the next job are high in different cycles.
- Simultaneous push and pop:
  - Permitted when not full; `count` stays unchanged.
  - When full, `req_ready`=0 even if a pop happens on the same edge; no bypass.
- Wrap-around: pointers wrap modulo `DEPTH`. FIFO order is preserved across the wrap.
- Reset mid-job: any in-flight job and all queued jobs are discarded with no completion report, and `start` drops immediately.

## Test plan
- Single job: push ID 3 at edge N; `done` 4 cycles after `start`. Required: `start` high during N+1→N+2; one `cmpl_valid` pulse with `cmpl_id`=3, `cmpl_timeout`=0; `busy` returns to 0.
- Fill and order: push IDs 1, 2, 3, 4, 5 on consecutive cycles with no `done`. Required: ID 1 pops immediately, IDs 2–5 queue, then `req_ready`=0 and `queue_count`=4. A 6th request sets `drop_err`=1 and is lost. Completions arrive in order 1, 2, 3, 4, 5, each separated by one gap cycle.
- Watchdog: push ID 7, never assert `done`. Required: `cmpl_valid` with `cmpl_id`=7 and `cmpl_timeout`=1 registered exactly 64 edges after `start` rose; the next queued job then starts.
- Coincident `done` and timeout: `done` on edge S+64. Required: `cmpl_timeout`=0.
- Stray `done` in `IDLE` while empty: no `cmpl_valid` and no state change. Then perform 9 push/complete cycles through a depth-4 FIFO. Required: IDs are returned correctly across the pointer wrap.
- Reset mid-job: assert `reset` asynchronously while in `WAIT` with 2 jobs queued. Required: all outputs go to their reset values immediately, and no completion is issued for the dropped jobs.
